// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, control-bit positions and occupancy state for pipeline stage registers
package pipe_pkg;

    localparam int REG_IDX_W = 5;
    localparam int WORD_W    = 32;

    // Positions of the per-instruction control bits inside the ctrl payload.
    localparam int CTRL_WREG_BIT  = 0;
    localparam int CTRL_M2REG_BIT = 1;
    localparam int CTRL_WMEM_BIT  = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+data+ctrl+rw register with load and clear
//   clock, reset        : clock, synchronous active-high reset (zeroes everything)
//   load                : capture in_* and mark valid (wins over clear)
//   clear               : mark invalid, payload retained
//   in_data/ctrl/rw     : payload to capture
//   valid/data/ctrl/rw  : registered contents
module pipe_slot import pipe_pkg::*; #(
    parameter int DATA_W = 2 * WORD_W,
    parameter int CTRL_W = 3,
    parameter int RW_W   = REG_IDX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RW_W-1:0]   in_rw,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [RW_W-1:0]   rw
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [RW_W-1:0]   rw_q,    rw_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        rw_d    = rw_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
            rw_d    = in_rw;
        end else if (clear) begin
            // Payload is kept so the stage output holds its last value when empty.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
            rw_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            rw_q    <= rw_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;
    assign rw    = rw_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline-stage register with skid buffer, flush and stall counter
//   clock, reset          : clock, synchronous active-high reset
//   flush                 : drop every held entry (and any entry accepted this cycle)
//   in_valid/in_ready     : upstream handshake; in_data/in_ctrl/in_rw upstream payload
//   out_valid/out_ready   : downstream handshake; out_data/out_ctrl/out_rw head payload
//   stall_cnt             : saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int DATA_W = 2 * WORD_W,
    parameter int CTRL_W = 3,
    parameter int RW_W   = REG_IDX_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RW_W-1:0]   in_rw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RW_W-1:0]   out_rw,
    output logic [CNT_W-1:0]  stall_cnt
);

    occ_t             state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic              head_load, head_clear, skid_load, skid_clear;
    logic              head_valid, skid_valid;
    logic [DATA_W-1:0] head_data, skid_data, head_src_data;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_src_ctrl;
    logic [RW_W-1:0]   head_rw,   skid_rw,   head_src_rw;
    logic              accept, issue;

    assign accept = in_valid & in_ready;
    assign issue  = head_valid & out_ready;

    // The skid entry is only ever valid in TWO, so it is the head's source exactly
    // when the head is being refilled from the skid.
    assign head_src_data = skid_valid ? skid_data : in_data;
    assign head_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign head_src_rw   = skid_valid ? skid_rw   : in_rw;

    always_comb begin
        state_d    = state_q;
        head_load  = 1'b0;
        head_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
            state_d    = OCC_EMPTY;
        end else if (SKID != 0) begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_load = 1'b1;
                        state_d   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && issue) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = OCC_TWO;
                    end else if (issue) begin
                        head_clear = 1'b1;
                        state_d    = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (issue) begin
                        head_load  = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = OCC_ONE;
                    end
                end
                default: begin
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = OCC_EMPTY;
                end
            endcase
        end else begin
            if (accept) begin
                head_load = 1'b1;
                state_d   = OCC_ONE;
            end else if (issue) begin
                head_clear = 1'b1;
                state_d    = OCC_EMPTY;
            end
        end

        // Registered ready: computed from next occupancy so out_ready never reaches in_ready.
        in_ready_d = (state_d != OCC_TWO);

        stall_d = stall_q;
        if (head_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RW_W(RW_W)) u_head (
        .clock   (clock),
        .reset   (reset),
        .load    (head_load),
        .clear   (head_clear),
        .in_data (head_src_data),
        .in_ctrl (head_src_ctrl),
        .in_rw   (head_src_rw),
        .valid   (head_valid),
        .data    (head_data),
        .ctrl    (head_ctrl),
        .rw      (head_rw)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RW_W(RW_W)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .in_rw   (in_rw),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl),
        .rw      (skid_rw)
    );

    assign in_ready  = (SKID != 0) ? in_ready_q : (!head_valid | out_ready);
    assign out_valid = head_valid;
    assign out_data  = head_data;
    // Bubbles must never carry write enables downstream.
    assign out_ctrl  = head_ctrl & {CTRL_W{head_valid}};
    assign out_rw    = head_rw;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (skid, no-skid and 4-bit counter builds)
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 64;
    localparam int CW = 3;
    localparam int RW = 5;
    localparam int EW = DW + CW + RW;
    typedef logic [EW-1:0] ent_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic [RW-1:0] in_rw;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [RW-1:0] out_rw;
    logic [15:0]   stall_cnt;

    logic          in_ready4, out_valid4;
    logic [DW-1:0] out_data4;
    logic [CW-1:0] out_ctrl4;
    logic [RW-1:0] out_rw4;
    logic [3:0]    stall_cnt4;

    logic          flush0, in0_valid, out0_ready;
    logic [DW-1:0] in0_data;
    logic [CW-1:0] in0_ctrl;
    logic [RW-1:0] in0_rw;
    logic          in_ready0, out_valid0;
    logic [DW-1:0] out_data0;
    logic [CW-1:0] out_ctrl0;
    logic [RW-1:0] out_rw0;
    logic [15:0]   stall_cnt0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RW_W(RW), .SKID(1), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_rw(in_rw), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .out_rw(out_rw),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RW_W(RW), .SKID(1), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_rw(in_rw), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .out_ctrl(out_ctrl4), .out_rw(out_rw4),
        .stall_cnt(stall_cnt4)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RW_W(RW), .SKID(0), .CNT_W(16)) dut0 (
        .clock(clock), .reset(reset), .flush(flush0), .in_valid(in0_valid), .in_ready(in_ready0),
        .in_data(in0_data), .in_ctrl(in0_ctrl), .in_rw(in0_rw), .out_valid(out_valid0),
        .out_ready(out0_ready), .out_data(out_data0), .out_ctrl(out_ctrl0), .out_rw(out_rw0),
        .stall_cnt(stall_cnt0)
    );

    int   checks   = 0;
    int   failures = 0;
    ent_t exp_q[$];
    ent_t exp0_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic [RW-1:0] r);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        in_rw    = r;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic [RW-1:0] r);
        exp_q.push_back({d, c, r});
    endtask

    // Monitor for the skid build: every issue must match the oldest expected entry.
    always @(negedge clock) begin : mon_skid
        ent_t e;
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue actual=%0h required=none t=%0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_data", out_data, e[EW-1 -: DW]);
                    chk("issue_ctrl", 64'(out_ctrl), 64'(e[CW+RW-1 -: CW]));
                    chk("issue_rw", 64'(out_rw), 64'(e[RW-1:0]));
                end
            end
            if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
        end
    end

    // Monitor for the no-skid build.
    always @(negedge clock) begin : mon_noskid
        ent_t e;
        if (!reset && out_valid0 && out0_ready) begin
            if (exp0_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue0 actual=%0h required=none t=%0t", out_data0, $time);
            end else begin
                e = exp0_q.pop_front();
                chk("issue0_data", out_data0, e[EW-1 -: DW]);
                chk("issue0_rw", 64'(out_rw0), 64'(e[RW-1:0]));
            end
        end
    end

    initial begin
        logic ov;
        logic exp_rdy;
        int   nxt;

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        flush0 = 1'b0; in0_valid = 1'b0; in0_data = '0; in0_ctrl = '0; in0_rw = '0; out0_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_rw", 64'(out_rw), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_in_ready0", 64'(in_ready0), 64'd1);

        // Streaming 1..4 with out_ready held: one-cycle latency, full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(i), 3'(i), 5'(i));
            #1;
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            push(64'(i), 3'(i), 5'(i));
            tick();
            chk("stream_out_valid", 64'(out_valid), 64'd1);
            chk("stream_latency_data", out_data, 64'(i));
        end
        drive(1'b0, '0, '0, '0);
        tick();
        chk("stream_drained", 64'(out_valid), 64'd0);
        tick();
        chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);

        // Bubble gating: control bits present while invalid
        drive(1'b0, 64'h77, 3'b111, 5'd7);
        repeat (2) begin
            tick();
            chk("bubble_out_valid", 64'(out_valid), 64'd0);
            chk("bubble_out_ctrl", 64'(out_ctrl), 64'd0);
        end

        // Backpressure into the skid entry
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 3'b010, 5'd10);
        #1;
        chk("bp_ready_a", 64'(in_ready), 64'd1);
        push(64'hA, 3'b010, 5'd10);
        tick();
        drive(1'b1, 64'hB, 3'b100, 5'd11);
        #1;
        chk("bp_ready_b", 64'(in_ready), 64'd1);
        push(64'hB, 3'b100, 5'd11);
        tick();
        drive(1'b1, 64'hEE, 3'b111, 5'd30);
        repeat (3) begin
            chk("bp_ready_full", 64'(in_ready), 64'd0);
            tick();
        end
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        tick();
        chk("bp_head_from_skid", out_data, 64'hB);
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd4);
        chk("bp_ready_back", 64'(in_ready), 64'd1);

        // Flush from TWO with a pending offer
        out_ready = 1'b0;
        drive(1'b1, 64'h10, 3'b111, 5'd16);
        #1;
        chk("fl_ready_10", 64'(in_ready), 64'd1);
        tick();
        drive(1'b1, 64'h11, 3'b111, 5'd17);
        tick();
        flush = 1'b1;
        drive(1'b1, 64'h12, 3'b111, 5'd18);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_stall_cnt", 64'(stall_cnt), 64'd6);

        // Flush from ONE while an entry is accepted in the same cycle
        drive(1'b1, 64'h20, 3'b011, 5'd20);
        tick();
        flush = 1'b1;
        drive(1'b1, 64'h21, 3'b011, 5'd21);
        #1;
        chk("fl1_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("fl1_out_valid", 64'(out_valid), 64'd0);
        chk("fl1_data_held", out_data, 64'h20);
        chk("fl1_stall_cnt", 64'(stall_cnt), 64'd7);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl1_stays_empty", 64'(out_valid), 64'd0);

        // Recovery after flush
        drive(1'b1, 64'h30, 3'b001, 5'd3);
        push(64'h30, 3'b001, 5'd3);
        tick();
        drive(1'b0, '0, '0, '0);
        tick();
        chk("rec_empty", 64'(out_valid), 64'd0);

        // Reset with both entries held
        out_ready = 1'b0;
        drive(1'b1, 64'h40, 3'b101, 5'd4);
        tick();
        drive(1'b1, 64'h41, 3'b101, 5'd5);
        tick();
        reset = 1'b1;
        drive(1'b0, '0, '0, '0);
        tick();
        reset = 1'b0;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_out_data", out_data, 64'd0);
        chk("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("mrst_stall_cnt4", 64'(stall_cnt4), 64'd0);
        out_ready = 1'b1;
        repeat (2) tick();

        // No-skid build: out_ready toggling 1,0,1,0 under continuous offers
        ov  = 1'b0;
        nxt = 0;
        for (int k = 0; k < 8; k++) begin
            out0_ready = (k % 2 == 0);
            in0_valid  = 1'b1;
            in0_data   = 64'h100 + 64'(nxt);
            in0_rw     = 5'(nxt);
            in0_ctrl   = 3'b001;
            #1;
            exp_rdy = !ov || out0_ready;
            chk("ns_in_ready", 64'(in_ready0), 64'(exp_rdy));
            if (exp_rdy) begin
                exp0_q.push_back({64'h100 + 64'(nxt), 3'b001, 5'(nxt)});
                nxt++;
                ov = 1'b1;
            end else if (ov && out0_ready) begin
                ov = 1'b0;
            end
            tick();
            chk("ns_out_valid", 64'(out_valid0), 64'(ov));
        end
        in0_valid  = 1'b0;
        out0_ready = 1'b1;
        repeat (3) tick();
        chk("ns_drained", 64'(out_valid0), 64'd0);

        // Saturation of the 4-bit counter
        out_ready = 1'b0;
        drive(1'b1, 64'h50, 3'b110, 5'd9);
        push(64'h50, 3'b110, 5'd9);
        tick();
        drive(1'b0, '0, '0, '0);
        repeat (15) tick();
        chk("sat_reach15", 64'(stall_cnt4), 64'd15);
        repeat (5) tick();
        chk("sat_hold15", 64'(stall_cnt4), 64'd15);
        chk("sat_wide20", 64'(stall_cnt), 64'd20);
        out_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sat_reset4", 64'(stall_cnt4), 64'd0);
        chk("sat_reset16", 64'(stall_cnt), 64'd0);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("sb0_empty", 64'(exp0_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
